// File: rtl/fifo_param_pkg.sv
// Package for fifo_param: default parameters and request decode helper.
package fifo_param_pkg;
`include "fifo_param_defs.sv"

   localparam int unsigned DEF_DATA_W = `FIFO_PARAM_DATA_W;
   localparam int unsigned DEF_ADDR_W = `FIFO_PARAM_ADDR_W;
   localparam int unsigned DEF_FWFT   = `FIFO_PARAM_FWFT;
   localparam int unsigned DEF_DEPTH  = `FIFO_PARAM_DEPTH;

   // Per-cycle decision on which requests are taken and whether an error fires.
   typedef struct packed {
      logic push_ok;
      logic pop_ok;
      logic err_set;
   } fifo_ctl_t;

   // A pop frees a slot on a full FIFO, so a simultaneous push is still taken.
   function automatic fifo_ctl_t fifo_decode(input logic enable,
                                             input logic push,
                                             input logic pop,
                                             input logic empty,
                                             input logic full);
      fifo_ctl_t c;
      c.pop_ok  = enable & pop & ~empty;
      c.push_ok = enable & push & (~full | c.pop_ok);
      c.err_set = enable & ((push & full & ~c.pop_ok) | (pop & empty));
      return c;
   endfunction

endpackage

// File: rtl/fifo_param_defs.sv
// Shared default geometry and read mode for fifo_param (RTL and bench).
`ifndef FIFO_PARAM_DEFS_SV
`define FIFO_PARAM_DEFS_SV
`define FIFO_PARAM_DATA_W 6
`define FIFO_PARAM_ADDR_W 2
`define FIFO_PARAM_FWFT   0
`define FIFO_PARAM_DEPTH  (1 << `FIFO_PARAM_ADDR_W)
`endif

// File: rtl/fifo_param_mem.sv
// fifo_param storage: register file, synchronous write, asynchronous read.
module fifo_param_mem
   import fifo_param_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data_c
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write port; contents are never reset, pointers make stale entries invisible.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data_c = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param: parameterised single-clock FIFO with status flags, sticky
// error and selectable registered / first-word-fall-through read.
module fifo_param
   import fifo_param_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned FWFT   = DEF_FWFT
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              enable,
   input  logic [ADDR_W-1:0] thr_empty,
   input  logic [ADDR_W-1:0] thr_full,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   input  logic              err_clr,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic              error
);

   localparam int unsigned   DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_error;
   logic [DATA_W-1:0] w_rd_data;
   logic              w_empty;
   logic              w_full;
   fifo_ctl_t         w_ctl;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == DEPTH_C);
   assign w_ctl   = fifo_decode(enable, push, pop, w_empty, w_full);

   // Pointer and occupancy tracking.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_ctl.push_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         if (w_ctl.pop_ok)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         if (w_ctl.push_ok && !w_ctl.pop_ok) begin
            r_count <= r_count + (ADDR_W+1)'(1);
         end else if (!w_ctl.push_ok && w_ctl.pop_ok) begin
            r_count <= r_count - (ADDR_W+1)'(1);
         end
      end
   end

   // Sticky error; a new error wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_error <= 1'b0;
      end else if (w_ctl.err_set) begin
         r_error <= 1'b1;
      end else if (enable && err_clr) begin
         r_error <= 1'b0;
      end
   end

   fifo_param_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk         (clk),
      .i_we        (w_ctl.push_ok & reset_L),
      .i_wr_addr   (r_wr_ptr),
      .i_wr_data   (data_in),
      .i_rd_addr   (r_rd_ptr),
      .o_rd_data_c (w_rd_data)
   );

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out  = w_rd_data;
         assign valid_out = ~w_empty;
      end else begin : g_reg
         logic [DATA_W-1:0] r_data_out;
         logic              r_valid_out;

         // Registered read: data captured on the pop, valid pulses for one cycle.
         always_ff @(posedge clk) begin
            if (!reset_L) begin
               r_data_out  <= '0;
               r_valid_out <= 1'b0;
            end else if (enable) begin
               r_valid_out <= w_ctl.pop_ok;
               if (w_ctl.pop_ok) r_data_out <= w_rd_data;
            end
         end

         assign data_out  = r_data_out;
         assign valid_out = r_valid_out;
      end
   endgenerate

   assign count        = r_count;
   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_empty = (r_count <= {1'b0, thr_empty});
   assign almost_full  = (r_count >= (DEPTH_C - {1'b0, thr_full}));
   assign error        = r_error;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: registered-read default instance, FWFT
// instance and a wider/deeper instance for pointer wrap and mid-stream reset.
`include "fifo_param_defs.sv"

module tb_fifo_param;

   localparam int unsigned AW = `FIFO_PARAM_ADDR_W;
   localparam int unsigned DW = `FIFO_PARAM_DATA_W;
   localparam int unsigned DEPTH = `FIFO_PARAM_DEPTH;

   logic clk;
   int   n_pass;
   int   n_total;

   // Instance A: defaults, registered read
   logic          a_rst_l, a_en, a_push, a_pop, a_clr;
   logic [AW-1:0] a_thr_e, a_thr_f;
   logic [DW-1:0] a_din, a_dout;
   logic          a_valid, a_empty, a_full, a_ae, a_af, a_err;
   logic [AW:0]   a_count;

   // Instance B: first-word-fall-through
   logic          b_rst_l, b_en, b_push, b_pop, b_clr;
   logic [AW-1:0] b_thr_e, b_thr_f;
   logic [DW-1:0] b_din, b_dout;
   logic          b_valid, b_empty, b_full, b_ae, b_af, b_err;
   logic [AW:0]   b_count;

   // Instance C: ADDR_W=3, DATA_W=8, registered read
   logic          c_rst_l, c_en, c_push, c_pop, c_clr;
   logic [2:0]    c_thr_e, c_thr_f;
   logic [7:0]    c_din, c_dout;
   logic          c_valid, c_empty, c_full, c_ae, c_af, c_err;
   logic [3:0]    c_count;

   fifo_param #(.DATA_W(DW), .ADDR_W(AW), .FWFT(`FIFO_PARAM_FWFT)) u_a (
      .clk(clk), .reset_L(a_rst_l), .enable(a_en), .thr_empty(a_thr_e), .thr_full(a_thr_f),
      .push(a_push), .pop(a_pop), .data_in(a_din), .err_clr(a_clr), .data_out(a_dout),
      .valid_out(a_valid), .count(a_count), .empty(a_empty), .full(a_full),
      .almost_empty(a_ae), .almost_full(a_af), .error(a_err));

   fifo_param #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1)) u_b (
      .clk(clk), .reset_L(b_rst_l), .enable(b_en), .thr_empty(b_thr_e), .thr_full(b_thr_f),
      .push(b_push), .pop(b_pop), .data_in(b_din), .err_clr(b_clr), .data_out(b_dout),
      .valid_out(b_valid), .count(b_count), .empty(b_empty), .full(b_full),
      .almost_empty(b_ae), .almost_full(b_af), .error(b_err));

   fifo_param #(.DATA_W(8), .ADDR_W(3), .FWFT(0)) u_c (
      .clk(clk), .reset_L(c_rst_l), .enable(c_en), .thr_empty(c_thr_e), .thr_full(c_thr_f),
      .push(c_push), .pop(c_pop), .data_in(c_din), .err_clr(c_clr), .data_out(c_dout),
      .valid_out(c_valid), .count(c_count), .empty(c_empty), .full(c_full),
      .almost_empty(c_ae), .almost_full(c_af), .error(c_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock on instance A; outputs are stable when the task returns.
   task automatic a_op(input logic ps, input logic pp, input logic [DW-1:0] d, input logic clr);
      a_push = ps; a_pop = pp; a_din = d; a_clr = clr;
      @(posedge clk); #1;
      a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0;
   endtask

   task automatic b_op(input logic en, input logic ps, input logic pp, input logic [DW-1:0] d,
                       input logic clr);
      b_en = en; b_push = ps; b_pop = pp; b_din = d; b_clr = clr;
      @(posedge clk); #1;
      b_en = 1'b1; b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0;
   endtask

   task automatic c_op(input logic rst_l, input logic ps, input logic pp, input logic [7:0] d);
      c_rst_l = rst_l; c_push = ps; c_pop = pp; c_din = d;
      @(posedge clk); #1;
      c_rst_l = 1'b1; c_push = 1'b0; c_pop = 1'b0;
   endtask

   task automatic test_reset;
      a_rst_l = 1'b0; b_rst_l = 1'b0; c_rst_l = 1'b0;
      a_en = 1'b1; b_en = 1'b1; c_en = 1'b1;
      a_push = 0; a_pop = 0; a_clr = 0; a_din = '0; a_thr_e = '0; a_thr_f = '0;
      b_push = 0; b_pop = 0; b_clr = 0; b_din = '0; b_thr_e = '0; b_thr_f = '0;
      c_push = 0; c_pop = 0; c_clr = 0; c_din = '0; c_thr_e = '0; c_thr_f = '0;
      repeat (2) @(posedge clk);
      #1;
      a_rst_l = 1'b1; b_rst_l = 1'b1; c_rst_l = 1'b1;
      n_total++;
      if ({a_count, a_empty, a_full, a_ae, a_af, a_valid, a_err} !== {3'd0, 6'b101000})
         $display("FAIL reset_a_flags got cnt=%0d e=%b f=%b ae=%b af=%b v=%b err=%b exp cnt=0 e=1 f=0 ae=1 af=0 v=0 err=0",
                  a_count, a_empty, a_full, a_ae, a_af, a_valid, a_err);
      else n_pass++;
      n_total++;
      if (a_dout !== 6'h00) $display("FAIL reset_a_dout got=%h exp=00", a_dout);
      else n_pass++;
      n_total++;
      if ({b_count, b_empty, b_full, b_ae, b_af, b_valid, b_err} !== {3'd0, 6'b101000})
         $display("FAIL reset_b_flags got cnt=%0d e=%b f=%b ae=%b af=%b v=%b err=%b exp cnt=0 e=1 f=0 ae=1 af=0 v=0 err=0",
                  b_count, b_empty, b_full, b_ae, b_af, b_valid, b_err);
      else n_pass++;
      n_total++;
      if ({c_count, c_empty, c_full, c_ae, c_af, c_valid, c_err, c_dout} !== {4'd0, 6'b101000, 8'h00})
         $display("FAIL reset_c_state got cnt=%0d e=%b f=%b ae=%b af=%b v=%b err=%b dout=%h",
                  c_count, c_empty, c_full, c_ae, c_af, c_valid, c_err, c_dout);
      else n_pass++;
   endtask

   task automatic test_fill_drain;
      for (int i = 1; i <= int'(DEPTH); i++) a_op(1'b1, 1'b0, DW'(i), 1'b0);
      n_total++;
      if (a_full !== 1'b1 || a_count !== 3'd4 || a_empty !== 1'b0)
         $display("FAIL fill_full got full=%b cnt=%0d empty=%b exp full=1 cnt=4 empty=0", a_full, a_count, a_empty);
      else n_pass++;
      for (int i = 1; i <= int'(DEPTH); i++) begin
         a_op(1'b0, 1'b1, '0, 1'b0);
         n_total++;
         if (a_dout !== DW'(i) || a_valid !== 1'b1)
            $display("FAIL drain_%0d got dout=%h v=%b exp dout=%h v=1", i, a_dout, a_valid, DW'(i));
         else n_pass++;
      end
      a_op(1'b0, 1'b0, '0, 1'b0);
      n_total++;
      if (a_valid !== 1'b0 || a_dout !== 6'h04 || a_empty !== 1'b1 || a_err !== 1'b0)
         $display("FAIL drain_idle got v=%b dout=%h empty=%b err=%b exp v=0 dout=04 empty=1 err=0",
                  a_valid, a_dout, a_empty, a_err);
      else n_pass++;
   endtask

   task automatic test_error;
      for (int i = 0; i < 4; i++) a_op(1'b1, 1'b0, 6'h11 + DW'(i), 1'b0);
      a_op(1'b1, 1'b0, 6'h3F, 1'b0);
      n_total++;
      if (a_err !== 1'b1 || a_count !== 3'd4)
         $display("FAIL overflow_err got err=%b cnt=%0d exp err=1 cnt=4", a_err, a_count);
      else n_pass++;
      a_op(1'b0, 1'b0, '0, 1'b1);
      n_total++;
      if (a_err !== 1'b0) $display("FAIL err_clr got=%b exp=0", a_err);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         a_op(1'b0, 1'b1, '0, 1'b0);
         n_total++;
         if (a_dout !== 6'h11 + DW'(i) || a_valid !== 1'b1)
            $display("FAIL overflow_contents_%0d got dout=%h v=%b exp dout=%h v=1", i, a_dout, a_valid, 6'h11 + DW'(i));
         else n_pass++;
      end
      a_op(1'b0, 1'b1, '0, 1'b0);
      n_total++;
      if (a_err !== 1'b1 || a_count !== 3'd0 || a_valid !== 1'b0)
         $display("FAIL underflow got err=%b cnt=%0d v=%b exp err=1 cnt=0 v=0", a_err, a_count, a_valid);
      else n_pass++;
      a_op(1'b0, 1'b0, '0, 1'b1);
      a_op(1'b0, 1'b1, '0, 1'b1);
      n_total++;
      if (a_err !== 1'b1) $display("FAIL err_vs_clr got=%b exp=1", a_err);
      else n_pass++;
      a_op(1'b0, 1'b0, '0, 1'b1);
      a_op(1'b1, 1'b1, 6'h22, 1'b0);
      n_total++;
      if (a_err !== 1'b1 || a_count !== 3'd1 || a_valid !== 1'b0)
         $display("FAIL empty_push_pop got err=%b cnt=%0d v=%b exp err=1 cnt=1 v=0", a_err, a_count, a_valid);
      else n_pass++;
      a_op(1'b0, 1'b1, '0, 1'b1);
      n_total++;
      if (a_dout !== 6'h22 || a_err !== 1'b0 || a_empty !== 1'b1)
         $display("FAIL empty_push_data got dout=%h err=%b empty=%b exp dout=22 err=0 empty=1", a_dout, a_err, a_empty);
      else n_pass++;
   endtask

   task automatic test_full_push_pop;
      logic [DW-1:0] exp_q [5];
      exp_q = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h2A};
      for (int i = 1; i <= 4; i++) a_op(1'b1, 1'b0, DW'(i), 1'b0);
      a_op(1'b1, 1'b1, 6'h2A, 1'b0);
      n_total++;
      if (a_count !== 3'd4 || a_full !== 1'b1 || a_err !== 1'b0 || a_dout !== 6'h01)
         $display("FAIL full_push_pop got cnt=%0d full=%b err=%b dout=%h exp cnt=4 full=1 err=0 dout=01",
                  a_count, a_full, a_err, a_dout);
      else n_pass++;
      for (int i = 1; i < 5; i++) begin
         a_op(1'b0, 1'b1, '0, 1'b0);
         n_total++;
         if (a_dout !== exp_q[i] || a_valid !== 1'b1)
            $display("FAIL full_push_pop_order_%0d got dout=%h v=%b exp dout=%h v=1", i, a_dout, a_valid, exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_thresholds;
      a_thr_e = 2'd1; a_thr_f = 2'd1;
      for (int c = 0; c <= 4; c++) begin
         #1;
         n_total++;
         if (a_ae !== (c <= 1) || a_af !== (c >= 3) || a_count !== 3'(c))
            $display("FAIL thr_count_%0d got ae=%b af=%b cnt=%0d exp ae=%b af=%b", c, a_ae, a_af, a_count,
                     c <= 1, c >= 3);
         else n_pass++;
         if (c < 4) a_op(1'b1, 1'b0, DW'(c), 1'b0);
      end
      a_thr_f = 2'd0;
      a_op(1'b0, 1'b1, '0, 1'b0);
      n_total++;
      if (a_af !== 1'b0) $display("FAIL thr_full0_cnt3 got=%b exp=0", a_af);
      else n_pass++;
      a_thr_f = 2'd3; a_thr_e = 2'd3;
      #1;
      n_total++;
      if (a_af !== 1'b1 || a_ae !== 1'b1)
         $display("FAIL thr_live got af=%b ae=%b exp af=1 ae=1", a_af, a_ae);
      else n_pass++;
      repeat (3) a_op(1'b0, 1'b1, '0, 1'b0);
      a_thr_e = '0; a_thr_f = '0;
   endtask

   task automatic test_fwft;
      b_op(1'b1, 1'b1, 1'b0, 6'h15, 1'b0);
      n_total++;
      if (b_dout !== 6'h15 || b_valid !== 1'b1 || b_count !== 3'd1)
         $display("FAIL fwft_first got dout=%h v=%b cnt=%0d exp dout=15 v=1 cnt=1", b_dout, b_valid, b_count);
      else n_pass++;
      b_op(1'b1, 1'b1, 1'b0, 6'h0A, 1'b0);
      n_total++;
      if (b_dout !== 6'h15 || b_count !== 3'd2)
         $display("FAIL fwft_second got dout=%h cnt=%0d exp dout=15 cnt=2", b_dout, b_count);
      else n_pass++;
      b_op(1'b0, 1'b1, 1'b1, 6'h33, 1'b1);
      n_total++;
      if (b_dout !== 6'h15 || b_count !== 3'd2 || b_valid !== 1'b1 || b_err !== 1'b0)
         $display("FAIL fwft_disabled got dout=%h cnt=%0d v=%b err=%b exp dout=15 cnt=2 v=1 err=0",
                  b_dout, b_count, b_valid, b_err);
      else n_pass++;
      b_op(1'b1, 1'b0, 1'b1, '0, 1'b0);
      n_total++;
      if (b_dout !== 6'h0A || b_count !== 3'd1)
         $display("FAIL fwft_pop got dout=%h cnt=%0d exp dout=0a cnt=1", b_dout, b_count);
      else n_pass++;
      b_op(1'b1, 1'b0, 1'b1, '0, 1'b0);
      n_total++;
      if (b_valid !== 1'b0 || b_empty !== 1'b1)
         $display("FAIL fwft_empty got v=%b empty=%b exp v=0 empty=1", b_valid, b_empty);
      else n_pass++;
      b_op(1'b0, 1'b0, 1'b1, '0, 1'b0);
      n_total++;
      if (b_err !== 1'b0 || b_count !== 3'd0)
         $display("FAIL fwft_disabled_underflow got err=%b cnt=%0d exp err=0 cnt=0", b_err, b_count);
      else n_pass++;
      b_op(1'b1, 1'b0, 1'b1, '0, 1'b0);
      b_op(1'b0, 1'b0, 1'b0, '0, 1'b1);
      n_total++;
      if (b_err !== 1'b1) $display("FAIL fwft_clr_disabled got=%b exp=1", b_err);
      else n_pass++;
      b_op(1'b1, 1'b0, 1'b0, '0, 1'b1);
      n_total++;
      if (b_err !== 1'b0 || b_full !== 1'b0 || b_ae !== 1'b1 || b_af !== 1'b0)
         $display("FAIL fwft_clr got err=%b full=%b ae=%b af=%b exp err=0 full=0 ae=1 af=0", b_err, b_full, b_ae, b_af);
      else n_pass++;
   endtask

   task automatic test_wrap;
      logic [7:0] q [$];
      logic [7:0] exp_d;
      logic [7:0] nxt;
      int         ops [20];
      ops = '{1,1,1,1,0,1,0,1,0,1,1,1,1,0,0,0,0,0,0,0};
      nxt = 8'hA0;
      foreach (ops[k]) begin
         if (ops[k] == 1) begin
            c_op(1'b1, 1'b1, 1'b0, nxt);
            q.push_back(nxt);
            nxt = nxt + 8'd1;
            n_total++;
            if (c_count !== 4'(q.size()))
               $display("FAIL wrap_push_%0d got cnt=%0d exp=%0d", k, c_count, q.size());
            else n_pass++;
         end else begin
            exp_d = q.pop_front();
            c_op(1'b1, 1'b0, 1'b1, 8'h00);
            n_total++;
            if (c_dout !== exp_d || c_valid !== 1'b1 || c_count !== 4'(q.size()))
               $display("FAIL wrap_pop_%0d got dout=%h v=%b cnt=%0d exp dout=%h v=1 cnt=%0d",
                        k, c_dout, c_valid, c_count, exp_d, q.size());
            else n_pass++;
         end
      end
      for (int i = 0; i < 3; i++) c_op(1'b1, 1'b1, 1'b0, 8'hB0 + 8'(i));
      c_op(1'b0, 1'b1, 1'b1, 8'hEE);
      n_total++;
      if (c_count !== 4'd0 || c_empty !== 1'b1 || c_valid !== 1'b0 || c_err !== 1'b0)
         $display("FAIL midstream_reset got cnt=%0d empty=%b v=%b err=%b exp cnt=0 empty=1 v=0 err=0",
                  c_count, c_empty, c_valid, c_err);
      else n_pass++;
      c_op(1'b1, 1'b1, 1'b0, 8'h55);
      c_op(1'b1, 1'b0, 1'b1, 8'h00);
      n_total++;
      if (c_dout !== 8'h55 || c_empty !== 1'b1 || c_full !== 1'b0)
         $display("FAIL post_reset_data got dout=%h empty=%b full=%b exp dout=55 empty=1 full=0",
                  c_dout, c_empty, c_full);
      else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_fill_drain();
      test_error();
      test_full_push_pop();
      test_thresholds();
      test_fwft();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DATA_W, default 6, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_W, default 2, SHALL set the pointer width, with DEPTH = 2^ADDR_W entries.
REQ-003 Parameter FWFT, default 0, SHALL select the read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset_L  in  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-006 enable  in  1  global enable; when low, push, pop and err_clr SHALL be ignored and all state held.
REQ-007 thr_empty  in  ADDR_W  almost-empty threshold.
REQ-008 thr_full  in  ADDR_W  almost-full margin.
REQ-009 push  in  1  write request.
REQ-010 pop  in  1  read request.
REQ-011 data_in  in  DATA_W  write data.
REQ-012 err_clr  in  1  clears the sticky error flag.
REQ-013 data_out  out  DATA_W  read data.
REQ-014 valid_out  out  1  data_out qualifier.
REQ-015 count  out  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-016 empty, full, almost_empty, almost_full, error  out  1 each  status flags.

Function
REQ-017 An accepted push (push & enable & (!full | pop_accepted)) SHALL write data_in at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-018 An accepted pop (pop & enable & !empty) SHALL read the entry at rd_ptr and increment rd_ptr modulo DEPTH.
REQ-019 count SHALL increment on an accepted push alone, decrement on an accepted pop alone, and hold when both or neither are accepted.
REQ-020 empty SHALL equal (count == 0) and full SHALL equal (count == DEPTH).
REQ-021 almost_empty SHALL equal (count <= thr_empty) and almost_full SHALL equal (count >= DEPTH - thr_full), both evaluated combinationally against the live thresholds.
REQ-022 When FWFT = 0, data_out SHALL be registered one cycle after an accepted pop, valid_out SHALL pulse high for exactly that cycle, and data_out SHALL hold its last value otherwise.
REQ-023 When FWFT = 1, data_out SHALL present the entry at rd_ptr with zero-cycle latency and valid_out SHALL equal !empty.
REQ-024 When full, push together with pop SHALL perform both operations, leaving count at DEPTH with no error.
REQ-025 When full, push without pop SHALL drop data_in, leave the contents unchanged, and set error.
REQ-026 When empty, pop SHALL be refused and SHALL set error; a push in the same cycle SHALL still be accepted.
REQ-027 error SHALL be sticky until err_clr is asserted with enable high; if a new error occurs in the same cycle as err_clr, error SHALL remain set.
REQ-028 While enable is low, no error SHALL be generated.

Reset
REQ-029 While reset_L is low at a clock edge, wr_ptr, rd_ptr and count SHALL reset to 0, and data_out, valid_out and error SHALL reset to 0.
REQ-030 After reset, empty SHALL be 1, full SHALL be 0, almost_full SHALL be 0, and almost_empty SHALL be 1.
REQ-031 Reset asserted mid-operation SHALL discard all stored data and override any push, pop or err_clr in that cycle; memory contents SHALL need no reset.

Structure
REQ-032 The default DATA_W, ADDR_W and FWFT values and the derived DEPTH SHALL live in a shared fifo_param_defs include file, used by the RTL and the bench.
REQ-033 Storage SHALL be a separate sub-module, fifo_param_mem: a DEPTH x DATA_W register file with one synchronous write port and one asynchronous read port.
REQ-034 The top-level block SHALL contain the pointers, count, flags, error logic and read-mode output logic.
REQ-035 The block SHALL be synthesisable to the team's cmos cell library, with the structural netlist matching the behavioural model cycle for cycle.

Verification (DATA_W=6, ADDR_W=2 unless stated)
REQ-036 Reset, then push 0x01..0x04 with FWFT=0 -> full=1 and count=4; four pops return 0x01..0x04 in order, each one cycle after its pop with valid_out high; then empty=1.
REQ-037 Full FIFO, push 0x3F without pop -> error=1 and contents unchanged; err_clr -> error=0; pop on empty -> error=1 and count stays 0.
REQ-038 Full FIFO, push 0x2A together with pop -> count stays 4, no error, and 0x2A is read last.
REQ-039 thr_empty=1, thr_full=1, step count 0..4 -> almost_empty=1 at counts 0-1, almost_full=1 at counts 3-4.
REQ-040 FWFT=1, push 0x15 -> next cycle data_out=0x15 with valid_out=1 before any pop; then enable=0 with push/pop -> no state change.
REQ-041 ADDR_W=3, DATA_W=8, push 10 writes with interleaved pops across pointer wrap -> data order preserved, reset_L low mid-stream -> count=0, empty=1 next cycle.
